// File: rtl/uart_cmd_parser.sv
// ASCII register-access command parser: "Raa<CR>" reads and "Waadd<CR>" writes an 8-bit bus.
// Bytes come from the uart rx FIFO; the ASCII reply goes out through the uart tx FIFO.
module uart_cmd_parser #(
    parameter logic [31:0] TIMEOUT = 32'd10_000_000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx_empty,
    input  logic [7:0] r_data,
    output logic       rd_uart,
    input  logic       tx_full,
    output logic [7:0] w_data,
    output logic       wr_uart,
    output logic [7:0] bus_addr,
    output logic [7:0] bus_wdata,
    output logic       bus_we,
    output logic       bus_re,
    input  logic [7:0] bus_rdata,
    output logic       cmd_err
);

    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_SP = 8'h20;

    typedef enum logic [3:0] {
        S_IDLE, S_GET_A1, S_GET_A0, S_GET_D1, S_GET_D0,
        S_GET_CR, S_EXEC, S_RD_WAIT, S_SEND, S_FLUSH
    } state_t;

    // Reply buffer: element 0 goes out first.
    localparam logic [3:0][7:0] REPLY_OK  = {8'h00, CH_LF, CH_CR, 8'h4B};
    localparam logic [3:0][7:0] REPLY_ERR = {8'h00, CH_LF, CH_CR, 8'h3F};

    state_t          state_q;
    logic            run_q;
    logic            is_wr_q;
    logic [7:0]      addr_q;
    logic [7:0]      data_q;
    logic [7:0]      bus_addr_q;
    logic [7:0]      bus_wdata_q;
    logic [3:0][7:0] buf_q;
    logic [1:0]      idx_q;
    logic [1:0]      last_q;
    logic [31:0]     tmo_q;

    logic       pop_st;
    logic       is_rd_ch;
    logic       is_wr_ch;
    logic       is_blank;
    logic       bad;
    logic [4:0] hex;

    // {valid, nibble}
    function automatic logic [4:0] hex_dec(input logic [7:0] c);
        if (c >= 8'h30 && c <= 8'h39)
            return {1'b1, c[3:0]};
        else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66))
            return {1'b1, c[3:0] + 4'd9};
        else
            return 5'b0;
    endfunction

    function automatic logic [7:0] hex_enc(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    always_comb begin
        pop_st = 1'b0;
        case (state_q)
            S_IDLE, S_GET_A1, S_GET_A0, S_GET_D1, S_GET_D0, S_GET_CR, S_FLUSH: pop_st = 1'b1;
            default: pop_st = 1'b0;
        endcase
        // run_q keeps every strobe low until the first clock after reset release.
        rd_uart  = run_q && pop_st && !rx_empty;
        is_rd_ch = (r_data == 8'h52) || (r_data == 8'h72);
        is_wr_ch = (r_data == 8'h57) || (r_data == 8'h77);
        is_blank = (r_data == CH_LF) || (r_data == CH_CR) || (r_data == CH_SP);
        hex      = hex_dec(r_data);
        bad      = 1'b0;
        case (state_q)
            S_IDLE:                                  bad = !(is_rd_ch || is_wr_ch || is_blank);
            S_GET_A1, S_GET_A0, S_GET_D1, S_GET_D0:  bad = !hex[4];
            S_GET_CR:                                bad = (r_data != CH_CR);
            default:                                 bad = 1'b0;
        endcase
        cmd_err = rd_uart && bad;
        bus_we  = (state_q == S_EXEC) && is_wr_q;
        bus_re  = (state_q == S_EXEC) && !is_wr_q;
        wr_uart = (state_q == S_SEND) && !tx_full;
        w_data  = wr_uart ? buf_q[idx_q] : 8'h00;
    end

    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            run_q       <= 1'b0;
            is_wr_q     <= 1'b0;
            addr_q      <= 8'h00;
            data_q      <= 8'h00;
            bus_addr_q  <= 8'h00;
            bus_wdata_q <= 8'h00;
            buf_q       <= '0;
            idx_q       <= 2'd0;
            last_q      <= 2'd0;
            tmo_q       <= 32'd0;
        end else begin
            run_q <= 1'b1;
            case (state_q)
                S_IDLE: begin
                    tmo_q <= 32'd0;
                    if (rd_uart) begin
                        if (is_rd_ch || is_wr_ch) begin
                            is_wr_q <= is_wr_ch;
                            state_q <= S_GET_A1;
                        end else if (bad) begin
                            state_q <= S_FLUSH;
                        end
                    end
                end
                S_GET_A1, S_GET_A0, S_GET_D1, S_GET_D0, S_GET_CR: begin
                    if (rd_uart) begin
                        tmo_q <= 32'd0;
                        if (bad) begin
                            // An offending CR already terminates the command: reply at once.
                            if (r_data == CH_CR) begin
                                buf_q   <= REPLY_ERR;
                                last_q  <= 2'd2;
                                idx_q   <= 2'd0;
                                state_q <= S_SEND;
                            end else begin
                                state_q <= S_FLUSH;
                            end
                        end else begin
                            case (state_q)
                                S_GET_A1: begin
                                    addr_q[7:4] <= hex[3:0];
                                    state_q     <= S_GET_A0;
                                end
                                S_GET_A0: begin
                                    addr_q[3:0] <= hex[3:0];
                                    state_q     <= is_wr_q ? S_GET_D1 : S_GET_CR;
                                end
                                S_GET_D1: begin
                                    data_q[7:4] <= hex[3:0];
                                    state_q     <= S_GET_D0;
                                end
                                S_GET_D0: begin
                                    data_q[3:0] <= hex[3:0];
                                    state_q     <= S_GET_CR;
                                end
                                default: begin
                                    bus_addr_q <= addr_q;
                                    if (is_wr_q)
                                        bus_wdata_q <= data_q;
                                    state_q <= S_EXEC;
                                end
                            endcase
                        end
                    end else if (rx_empty && TIMEOUT != 32'd0) begin
                        if (tmo_q >= TIMEOUT - 32'd1) begin
                            tmo_q   <= 32'd0;
                            state_q <= S_IDLE;
                        end else begin
                            tmo_q <= tmo_q + 32'd1;
                        end
                    end
                end
                S_EXEC: begin
                    if (is_wr_q) begin
                        buf_q   <= REPLY_OK;
                        last_q  <= 2'd2;
                        idx_q   <= 2'd0;
                        state_q <= S_SEND;
                    end else begin
                        state_q <= S_RD_WAIT;
                    end
                end
                S_RD_WAIT: begin
                    buf_q   <= {CH_LF, CH_CR, hex_enc(bus_rdata[3:0]), hex_enc(bus_rdata[7:4])};
                    last_q  <= 2'd3;
                    idx_q   <= 2'd0;
                    state_q <= S_SEND;
                end
                S_SEND: begin
                    if (!tx_full) begin
                        idx_q <= idx_q + 2'd1;
                        if (idx_q == last_q)
                            state_q <= S_IDLE;
                    end
                end
                S_FLUSH: begin
                    tmo_q <= 32'd0;
                    if (rd_uart && r_data == CH_CR) begin
                        buf_q   <= REPLY_ERR;
                        last_q  <= 2'd2;
                        idx_q   <= 2'd0;
                        state_q <= S_SEND;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser: FIFO and bus models, per-scenario tasks with inline checks.
module tb_uart_cmd_parser;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       rx_empty, rd_uart, tx_full = 1'b0, wr_uart;
    logic       bus_we, bus_re, cmd_err;
    logic [7:0] r_data, w_data, bus_addr, bus_wdata;
    logic [7:0] bus_rdata = 8'hEE;
    logic [7:0] rd_val = 8'h00;

    logic [7:0] rxm [0:255];
    int         wp = 0, rp = 0;

    logic [7:0] txb [0:255];
    int         txc [0:255];
    int         tx_n = 0, we_n = 0, re_n = 0, err_n = 0, viol = 0, pop_n = 0;
    int         cyc = 0, last_pop_cyc = 0, we_cyc = 0, re_cyc = 0;
    logic [7:0] we_addr = 0, we_data = 0, re_addr = 0, err_byte = 0;

    int checks = 0, errors = 0;

    uart_cmd_parser #(.TIMEOUT(32'd100)) dut (
        .clk(clk), .reset_n(reset_n), .rx_empty(rx_empty), .r_data(r_data), .rd_uart(rd_uart),
        .tx_full(tx_full), .w_data(w_data), .wr_uart(wr_uart), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_we(bus_we), .bus_re(bus_re), .bus_rdata(bus_rdata),
        .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    assign rx_empty = (wp == rp);
    assign r_data   = rxm[rp[7:0]];

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (rd_uart && !rx_empty) rp <= rp + 1;
    // Read data is only meaningful in the cycle after bus_re.
    always @(posedge clk) bus_rdata <= bus_re ? rd_val : 8'hEE;

    always @(negedge clk) begin
        if (rd_uart) begin pop_n++; last_pop_cyc = cyc; end
        if (wr_uart) begin txb[tx_n[7:0]] = w_data; txc[tx_n[7:0]] = cyc; tx_n++; end
        if (bus_we) begin we_n++; we_addr = bus_addr; we_data = bus_wdata; we_cyc = cyc; end
        if (bus_re) begin re_n++; re_addr = bus_addr; re_cyc = cyc; end
        if (cmd_err) begin err_n++; err_byte = r_data; end
        if ((wr_uart && tx_full) || (rd_uart && rx_empty)) viol++;
    end

    task automatic push(input logic [7:0] b);
        rxm[wp[7:0]] = b;
        wp++;
    endtask

    task automatic send_cmd(input string s);
        for (int i = 0; i < s.len(); i++) push(s[i]);
        push(8'h0D);
    endtask

    task automatic wait_tx(input int base, input int n, input int budget);
        int k = 0;
        while ((tx_n - base) < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        #1 reset_n = 1'b0;
        push(8'h20);
        repeat (3) @(negedge clk);
        checks++;
        if ({rd_uart, wr_uart, bus_we, bus_re, cmd_err} !== 5'b0 || w_data !== 8'h00 ||
            bus_addr !== 8'h00 || bus_wdata !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs got rd=%b wr=%b we=%b re=%b err=%b wd=%h a=%h d=%h need all 0",
                     rd_uart, wr_uart, bus_we, bus_re, cmd_err, w_data, bus_addr, bus_wdata);
        end
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (rp != wp || err_n != 0 || tx_n != 0) begin
            errors++;
            $display("FAIL reset_space rp=%0d wp=%0d err=%0d tx=%0d need space popped silently",
                     rp, wp, err_n, tx_n);
        end
    endtask

    task automatic test_write();
        int b = tx_n, w = we_n, r = re_n, e = err_n;
        logic [7:0] exp [3] = '{8'h4B, 8'h0D, 8'h0A};
        send_cmd("W1A5B");
        wait_tx(b, 3, 60);
        checks++;
        if (we_n - w != 1 || we_addr !== 8'h1A || we_data !== 8'h5B) begin
            errors++;
            $display("FAIL write_bus n=%0d addr=%h data=%h need 1 1a 5b", we_n - w, we_addr, we_data);
        end
        checks++;
        if (re_n != r || err_n != e || tx_n - b != 3) begin
            errors++;
            $display("FAIL write_side re=%0d err=%0d tx=%0d need 0 0 3", re_n - r, err_n - e, tx_n - b);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (txb[b + i] !== exp[i]) begin
                errors++;
                $display("FAIL write_byte%0d got %h need %h", i, txb[b + i], exp[i]);
            end
        end
        checks++;
        if (we_cyc != last_pop_cyc + 1 || txc[b] != last_pop_cyc + 2) begin
            errors++;
            $display("FAIL write_latency strobe=+%0d tx=+%0d need +1 +2",
                     we_cyc - last_pop_cyc, txc[b] - last_pop_cyc);
        end
    endtask

    task automatic test_read();
        int b = tx_n, w = we_n, r = re_n;
        logic [7:0] exp [4] = '{8'h43, 8'h33, 8'h0D, 8'h0A};
        rd_val = 8'hC3;
        send_cmd("r1a");
        wait_tx(b, 4, 60);
        checks++;
        if (re_n - r != 1 || re_addr !== 8'h1A || we_n != w) begin
            errors++;
            $display("FAIL read_bus re=%0d addr=%h we=%0d need 1 1a 0", re_n - r, re_addr, we_n - w);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (txb[b + i] !== exp[i]) begin
                errors++;
                $display("FAIL read_byte%0d got %h need %h", i, txb[b + i], exp[i]);
            end
        end
        checks++;
        if (re_cyc != last_pop_cyc + 1 || txc[b] != last_pop_cyc + 3) begin
            errors++;
            $display("FAIL read_latency strobe=+%0d tx=+%0d need +1 +3",
                     re_cyc - last_pop_cyc, txc[b] - last_pop_cyc);
        end
        checks++;
        if (bus_wdata !== 8'h5B || bus_addr !== 8'h1A) begin
            errors++;
            $display("FAIL read_hold addr=%h wdata=%h need 1a 5b", bus_addr, bus_wdata);
        end
    endtask

    task automatic test_flush();
        int b = tx_n, w = we_n, r = re_n, e = err_n;
        logic [7:0] exp [3] = '{8'h3F, 8'h0D, 8'h0A};
        send_cmd("WG1");
        wait_tx(b, 3, 60);
        checks++;
        if (err_n - e != 1 || err_byte !== 8'h47 || we_n != w || re_n != r || rp != wp) begin
            errors++;
            $display("FAIL flush_err n=%0d byte=%h we=%0d re=%0d left=%0d need 1 47 0 0 0",
                     err_n - e, err_byte, we_n - w, re_n - r, wp - rp);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (txb[b + i] !== exp[i] || tx_n - b != 3) begin
                errors++;
                $display("FAIL flush_byte%0d got %h need %h (count %0d)", i, txb[b + i], exp[i], tx_n - b);
            end
        end
    endtask

    task automatic test_boundary();
        int b = tx_n, w = we_n, e = err_n;
        logic [7:0] exp [9] = '{8'h3F, 8'h0D, 8'h0A, 8'h4B, 8'h0D, 8'h0A, 8'h3F, 8'h0D, 8'h0A};
        push(8'h0A); push(8'h20); push(8'h0D);
        send_cmd("X");
        send_cmd("wFfa0");
        send_cmd("R1");
        wait_tx(b, 9, 200);
        checks++;
        if (we_n - w != 1 || we_addr !== 8'hFF || we_data !== 8'hA0) begin
            errors++;
            $display("FAIL bnd_write n=%0d addr=%h data=%h need 1 ff a0", we_n - w, we_addr, we_data);
        end
        checks++;
        if (err_n - e != 2 || err_byte !== 8'h0D) begin
            errors++;
            $display("FAIL bnd_err n=%0d last=%h need 2 0d", err_n - e, err_byte);
        end
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (txb[b + i] !== exp[i]) begin
                errors++;
                $display("FAIL bnd_byte%0d got %h need %h", i, txb[b + i], exp[i]);
            end
        end
    endtask

    task automatic test_tx_stall();
        int b = tx_n;
        logic [7:0] exp [4] = '{8'h33, 8'h43, 8'h0D, 8'h0A};
        rd_val = 8'h3C;
        tx_full = 1'b1;
        send_cmd("R3C");
        repeat (50) @(negedge clk);
        checks++;
        if (tx_n != b || viol != 0) begin
            errors++;
            $display("FAIL stall_hold tx=%0d viol=%0d need 0 0", tx_n - b, viol);
        end
        tx_full = 1'b0;
        wait_tx(b, 4, 40);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (txb[b + i] !== exp[i]) begin
                errors++;
                $display("FAIL stall_byte%0d got %h need %h", i, txb[b + i], exp[i]);
            end
        end
        checks++;
        if (txc[b + 3] != txc[b] + 3) begin
            errors++;
            $display("FAIL stall_b2b span=%0d need 3", txc[b + 3] - txc[b]);
        end
    endtask

    task automatic test_back_to_back();
        int b = tx_n, w = we_n, r = re_n;
        logic [7:0] exp [7] = '{8'h4B, 8'h0D, 8'h0A, 8'h35, 8'h41, 8'h0D, 8'h0A};
        rd_val = 8'h5A;
        send_cmd("W0102");
        send_cmd("R01");
        wait_tx(b, 7, 100);
        checks++;
        if (we_n - w != 1 || re_n - r != 1 || re_addr !== 8'h01 || re_cyc <= txc[b + 2]) begin
            errors++;
            $display("FAIL b2b_bus we=%0d re=%0d addr=%h re_cyc=%0d lastK=%0d need 1 1 01 re after reply",
                     we_n - w, re_n - r, re_addr, re_cyc, txc[b + 2]);
        end
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (txb[b + i] !== exp[i]) begin
                errors++;
                $display("FAIL b2b_byte%0d got %h need %h", i, txb[b + i], exp[i]);
            end
        end
    endtask

    task automatic test_timeout();
        int b = tx_n, w = we_n, r = re_n, e = err_n;
        logic [7:0] exp [4] = '{8'h30, 8'h30, 8'h0D, 8'h0A};
        push(8'h57); push(8'h31);
        repeat (150) @(negedge clk);
        checks++;
        if (err_n != e || tx_n != b || rp != wp) begin
            errors++;
            $display("FAIL tmo_silent err=%0d tx=%0d left=%0d need 0 0 0", err_n - e, tx_n - b, wp - rp);
        end
        rd_val = 8'h00;
        send_cmd("R00");
        wait_tx(b, 4, 60);
        checks++;
        if (we_n != w || re_n - r != 1 || re_addr !== 8'h00 || err_n != e) begin
            errors++;
            $display("FAIL tmo_read we=%0d re=%0d addr=%h err=%0d need 0 1 00 0",
                     we_n - w, re_n - r, re_addr, err_n - e);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (txb[b + i] !== exp[i]) begin
                errors++;
                $display("FAIL tmo_byte%0d got %h need %h", i, txb[b + i], exp[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int b = tx_n, k = 0;
        logic [7:0] exp [4] = '{8'h37, 8'h45, 8'h0D, 8'h0A};
        rd_val = 8'h99;
        send_cmd("R12");
        while (!bus_re && k < 40) begin @(negedge clk); k++; end
        checks++;
        if (!bus_re) begin
            errors++;
            $display("FAIL rstmid_strobe got no bus_re within 40 cycles");
        end
        @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        checks++;
        if ({rd_uart, wr_uart, bus_we, bus_re, cmd_err} !== 5'b0 || w_data !== 8'h00 ||
            bus_addr !== 8'h00 || bus_wdata !== 8'h00) begin
            errors++;
            $display("FAIL rstmid_outputs rd=%b wr=%b we=%b re=%b err=%b wd=%h a=%h d=%h need all 0",
                     rd_uart, wr_uart, bus_we, bus_re, cmd_err, w_data, bus_addr, bus_wdata);
        end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if (tx_n != b) begin
            errors++;
            $display("FAIL rstmid_noreply tx=%0d need 0", tx_n - b);
        end
        rd_val = 8'h7E;
        send_cmd("R05");
        wait_tx(b, 4, 60);
        checks++;
        if (re_addr !== 8'h05 || tx_n - b != 4 || viol != 0) begin
            errors++;
            $display("FAIL rstmid_read addr=%h tx=%0d viol=%0d need 05 4 0", re_addr, tx_n - b, viol);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (txb[b + i] !== exp[i]) begin
                errors++;
                $display("FAIL rstmid_byte%0d got %h need %h", i, txb[b + i], exp[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_flush();
        test_boundary();
        test_tx_stall();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
